// File: rtl/cond_logic.sv
// cond_logic: architectural NZCV flag register, ARM condition evaluation and
// condition gating of the multicycle controller's write strobes.
module cond_logic #(
  parameter int COND_W = 4,  // condition field width, fixed by the ISA
  parameter int FLAG_W = 4   // flag vector width, {N,Z,C,V} = [3:0]
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COND_W-1:0] Cond,
  input  logic [FLAG_W-1:0] ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              InstrStart,
  input  logic              PCS,
  input  logic              NextPC,
  input  logic              RegW,
  input  logic              MemW,
  output logic [FLAG_W-1:0] Flags,
  output logic              CondEx,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic              MemWrite
);

  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_d;
  logic              condex_q;
  logic              condex_d;
  logic              cond_met;

  // Individual stored flags, named for readability of the condition table.
  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Condition evaluation always looks at the stored flags, never at ALUFlags.
  always_comb begin
    cond_met = 1'b0;
    case (Cond)
      4'b0000: cond_met = flag_z;                              // EQ
      4'b0001: cond_met = ~flag_z;                             // NE
      4'b0010: cond_met = flag_c;                              // CS
      4'b0011: cond_met = ~flag_c;                             // CC
      4'b0100: cond_met = flag_n;                              // MI
      4'b0101: cond_met = ~flag_n;                             // PL
      4'b0110: cond_met = flag_v;                              // VS
      4'b0111: cond_met = ~flag_v;                             // VC
      4'b1000: cond_met = flag_c & ~flag_z;                    // HI
      4'b1001: cond_met = ~flag_c | flag_z;                    // LS
      4'b1010: cond_met = ~(flag_n ^ flag_v);                  // GE
      4'b1011: cond_met = flag_n ^ flag_v;                     // LT
      4'b1100: cond_met = ~flag_z & ~(flag_n ^ flag_v);        // GT
      4'b1101: cond_met = flag_z | (flag_n ^ flag_v);          // LE
      default: cond_met = 1'b1;                                // AL / unconditional
    endcase
  end

  // Condition result is captured only at decode and held for the whole instruction.
  always_comb begin
    condex_d = condex_q;
    if (InstrStart) begin
      condex_d = cond_met;
    end
  end

  // Each flag half ({N,Z} and {C,V}) has its own write enable, gated by the
  // condition result already latched for this instruction (the old CondEx when
  // InstrStart coincides with a flag write).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag_half
      assign flags_d[gi*2 +: 2] = (FlagW[gi] && condex_q) ? ALUFlags[gi*2 +: 2]
                                                          : flags_q[gi*2 +: 2];
    end
  endgenerate

  // State registers; reset clears both flags and any latched condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= '0;
      condex_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  assign Flags  = flags_q;
  assign CondEx = condex_q;

  // Strobes follow the controller combinationally; fetch (NextPC) is never gated.
  assign PCWrite  = (PCS & condex_q) | NextPC;
  assign RegWrite = RegW & condex_q;
  assign MemWrite = MemW & condex_q;

endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: directed plus randomized checks of cond_logic against a
// behavioural model of the flag register and ARM condition codes.
module tb_cond_logic;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       InstrStart;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic [3:0] Flags;
  logic       CondEx;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;

  int checks = 0;
  int errors = 0;

  cond_logic dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagW      (FlagW),
    .InstrStart (InstrStart),
    .PCS        (PCS),
    .NextPC     (NextPC),
    .RegW       (RegW),
    .MemW       (MemW),
    .Flags      (Flags),
    .CondEx     (CondEx),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference condition: ARM codes come in pairs, odd code = negation of even.
  function automatic bit model_eval(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = (n == v) && !z;
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b1;
    return base ^ c[0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  logic [3:0] m_flags;
  bit         m_cex;
  bit         model_ok = 1'b0;

  always @(posedge clk) begin
    logic [3:0] nf;
    if (reset) begin
      m_flags  <= 4'b0000;
      m_cex    <= 1'b0;
      model_ok <= 1'b1;
    end else begin
      nf = m_flags;
      if (FlagW[1] && m_cex) nf[3:2] = ALUFlags[3:2];
      if (FlagW[0] && m_cex) nf[1:0] = ALUFlags[1:0];
      if (InstrStart) m_cex <= model_eval(Cond, m_flags);
      m_flags <= nf;
    end
  end

  // Every cycle, mid-period, compare all outputs against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_flags",    {28'd0, Flags},    {28'd0, m_flags});
      chk("model_condex",   {31'd0, CondEx},   {31'd0, m_cex});
      chk("model_pcwrite",  {31'd0, PCWrite},  {31'd0, (PCS & m_cex) | NextPC});
      chk("model_regwrite", {31'd0, RegWrite}, {31'd0, RegW & m_cex});
      chk("model_memwrite", {31'd0, MemWrite}, {31'd0, MemW & m_cex});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Cond = 4'b0000; ALUFlags = 4'b0000; FlagW = 2'b00; InstrStart = 1'b0;
    PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
  endtask

  // Make CondEx true with AL, then load all four flags.
  task automatic load_flags(input logic [3:0] f);
    InstrStart = 1'b1; Cond = 4'b1110; step(); InstrStart = 1'b0;
    FlagW = 2'b11; ALUFlags = f; step(); FlagW = 2'b00;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    // Reset state and AL instruction.
    @(negedge clk);
    chk("reset_flags",  {28'd0, Flags},  32'h0);
    chk("reset_condex", {31'd0, CondEx}, 32'h0);
    step();
    InstrStart = 1'b1; Cond = 4'b1110; RegW = 1'b1;
    step(); InstrStart = 1'b0;
    @(negedge clk);
    chk("al_condex",   {31'd0, CondEx},   32'h1);
    chk("al_regwrite", {31'd0, RegWrite}, 32'h1);
    chk("al_flags",    {28'd0, Flags},    32'h0);
    RegW = 1'b0;

    // EQ passes with Z set, NE fails.
    load_flags(4'b0100);
    InstrStart = 1'b1; Cond = 4'b0000; step(); InstrStart = 1'b0;
    MemW = 1'b1; PCS = 1'b1;
    @(negedge clk);
    chk("eq_memwrite", {31'd0, MemWrite}, 32'h1);
    chk("eq_pcwrite",  {31'd0, PCWrite},  32'h1);
    MemW = 1'b0; PCS = 1'b0;
    step();
    InstrStart = 1'b1; Cond = 4'b0001; step(); InstrStart = 1'b0;
    MemW = 1'b1; PCS = 1'b1;
    @(negedge clk);
    chk("ne_memwrite", {31'd0, MemWrite}, 32'h0);
    chk("ne_pcwrite",  {31'd0, PCWrite},  32'h0);
    MemW = 1'b0; PCS = 1'b0;

    // Independent flag halves.
    load_flags(4'b0001);
    FlagW = 2'b10; ALUFlags = 4'b1011; step(); FlagW = 2'b00;
    @(negedge clk);
    chk("half_nz", {28'd0, Flags}, 32'h9);
    FlagW = 2'b01; ALUFlags = 4'b0110; step(); FlagW = 2'b00;
    @(negedge clk);
    chk("half_cv", {28'd0, Flags}, 32'hA);

    // Failed condition suppresses flag writes and strobes, not fetch.
    load_flags(4'b0000);
    InstrStart = 1'b1; Cond = 4'b1011; step(); InstrStart = 1'b0;
    FlagW = 2'b11; ALUFlags = 4'b1111; RegW = 1'b1; step(); FlagW = 2'b00;
    @(negedge clk);
    chk("lt_condex",   {31'd0, CondEx},   32'h0);
    chk("lt_flags",    {28'd0, Flags},    32'h0);
    chk("lt_regwrite", {31'd0, RegWrite}, 32'h0);
    NextPC = 1'b1; step();
    @(negedge clk);
    chk("lt_nextpc", {31'd0, PCWrite}, 32'h1);
    idle();

    // Sweep every condition against every flag value.
    for (int f = 0; f < 16; f++) begin
      load_flags(f[3:0]);
      for (int c = 0; c < 16; c++) begin
        InstrStart = 1'b1; Cond = c[3:0]; step(); InstrStart = 1'b0;
        @(negedge clk);
        if (c == 12 && f == 8)  chk("gt_f1000", {31'd0, CondEx}, 32'h0);
        if (c == 12 && f == 9)  chk("gt_f1001", {31'd0, CondEx}, 32'h1);
        if (c == 8  && f == 2)  chk("hi_f0010", {31'd0, CondEx}, 32'h1);
        if (c == 8  && f == 6)  chk("hi_f0110", {31'd0, CondEx}, 32'h0);
        if (c == 8  && f == 0)  chk("hi_f0000", {31'd0, CondEx}, 32'h0);
        if (c == 10 && f == 9)  chk("ge_f1001", {31'd0, CondEx}, 32'h1);
        if (c == 13 && f == 8)  chk("le_f1000", {31'd0, CondEx}, 32'h1);
      end
    end

    // Mid-instruction reset discards CondEx and flags.
    load_flags(4'b1111);
    InstrStart = 1'b1; Cond = 4'b1110; step(); InstrStart = 1'b0;
    RegW = 1'b1; reset = 1'b1; step(); reset = 1'b0;
    @(negedge clk);
    chk("rst_condex",   {31'd0, CondEx},   32'h0);
    chk("rst_flags",    {28'd0, Flags},    32'h0);
    chk("rst_regwrite", {31'd0, RegWrite}, 32'h0);
    idle();

    // Randomized traffic, including coincident InstrStart/flag writes.
    for (int i = 0; i < 3000; i++) begin
      Cond       = 4'($urandom);
      ALUFlags   = 4'($urandom);
      FlagW      = 2'($urandom);
      InstrStart = ($urandom_range(0, 3) == 0);
      PCS        = 1'($urandom);
      NextPC     = ($urandom_range(0, 3) == 0);
      RegW       = 1'($urandom);
      MemW       = 1'($urandom);
      reset      = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    step();
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
